pwm_irq_router: RTL

- Parametrised interrupt router for the multi-channel PWM core.
- Takes N_SRC per-channel PWM event lines. Each source is qualified as edge- or level-sensitive, latched into a pending register, and routed through a per-output mask matrix to N_OUT interrupt lines.
- Each output has an event-coalescing counter, a sticky interrupt with acknowledge, an overrun flag and a lowest-index source ID.
- Sits between the PWM channel array and the AXI4-Lite register file and PS interrupt pins.

---
 rtl/pwm_irq_router.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pwm_irq_router.sv
// Interrupt router for the multi-channel PWM core: qualifies edge/level events, latches them
// as pending, and routes them through per-output masks to coalescing sticky interrupt lines.

module pwm_irq_out #(
    parameter int N_SRC = 8,
    parameter int CNT_W = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] ev,
    input  logic [N_SRC-1:0] mask,
    input  logic [N_SRC-1:0] pending,
    input  logic [CNT_W-1:0] thresh,
    input  logic             ack,
    output logic             irq_out,
    output logic             overrun,
    output logic [ID_W-1:0]  irq_id,
    output logic             irq_id_vld
);
    typedef enum logic [1:0] {IDLE = 2'd0, ASSERTED = 2'd1, OVERRUN = 2'd2} state_t;

    localparam logic [CNT_W:0] ONE = 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W:0]   cnt_inc, thr_eff;
    logic             hit, fire;
    logic [N_SRC-1:0] pend_masked;
    logic [ID_W-1:0]  id_nxt;
    logic             vld_nxt;

    // One extra bit keeps cnt+1 from wrapping when the counter sits at its maximum.
    assign cnt_inc     = {1'b0, cnt} + ONE;
    assign thr_eff     = (thresh == '0) ? ONE : {1'b0, thresh};
    assign hit         = |(ev & mask);
    assign fire        = hit && (cnt_inc >= thr_eff);
    assign pend_masked = pending & mask;

    always_comb begin
        cnt_nxt = cnt;
        if (fire)
            cnt_nxt = '0;
        else if (hit)
            cnt_nxt = cnt_inc[CNT_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (fire) state_nxt = ASSERTED;
            ASSERTED: begin
                if (fire)     state_nxt = ack ? ASSERTED : OVERRUN;
                else if (ack) state_nxt = IDLE;
            end
            OVERRUN:  begin
                if (fire)     state_nxt = ack ? ASSERTED : OVERRUN;
                else if (ack) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Descending scan so the lowest set index is the last to be written.
    always_comb begin
        id_nxt  = '0;
        vld_nxt = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend_masked[i]) begin
                id_nxt  = ID_W'(i);
                vld_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            irq_id     <= '0;
            irq_id_vld <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            irq_id     <= id_nxt;
            irq_id_vld <= vld_nxt;
        end
    end

    assign irq_out = (state != IDLE);
    assign overrun = (state == OVERRUN);
endmodule

module pwm_irq_router #(
    parameter int N_SRC = 8,
    parameter int N_OUT = 2,
    parameter int CNT_W = 8,
    parameter int ID_W  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC-1:0]       irq_src,
    input  logic [N_SRC-1:0]       edge_mode,
    input  logic [N_OUT*N_SRC-1:0] route_mask,
    input  logic [N_OUT*CNT_W-1:0] coal_thresh,
    input  logic [N_SRC-1:0]       pend_clr,
    input  logic [N_OUT-1:0]       ack,
    output logic [N_OUT-1:0]       irq_out,
    output logic [N_OUT-1:0]       overrun,
    output logic [N_SRC-1:0]       pending,
    output logic [N_OUT*ID_W-1:0]  irq_id,
    output logic [N_OUT-1:0]       irq_id_vld
);
    logic [N_SRC-1:0] src_d, ev;

    // Level sources ignore history, so masking src_d by edge_mode covers both modes.
    assign ev = irq_src & ~(src_d & edge_mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_d   <= '0;
            pending <= '0;
        end else begin
            src_d   <= irq_src;
            pending <= (pending & ~pend_clr) | ev;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        pwm_irq_out #(.N_SRC(N_SRC), .CNT_W(CNT_W), .ID_W(ID_W)) u_out (
            .clk        (clk),
            .reset      (reset),
            .ev         (ev),
            .mask       (route_mask[k*N_SRC +: N_SRC]),
            .pending    (pending),
            .thresh     (coal_thresh[k*CNT_W +: CNT_W]),
            .ack        (ack[k]),
            .irq_out    (irq_out[k]),
            .overrun    (overrun[k]),
            .irq_id     (irq_id[k*ID_W +: ID_W]),
            .irq_id_vld (irq_id_vld[k])
        );
    end
endmodule
